// File: rtl/interval_scheduler_pkg.sv
// Shared definitions for the interval scheduler: FSM state encoding and default sizes.
package interval_sched_pkg;
  localparam int DEF_NUM_REQ = 4;
  localparam int DEF_CNT_W   = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    RUN   = 2'd2,
    DONE  = 2'd3
  } state_t;
endpackage

// File: rtl/interval_scheduler_if.sv
// Request/grant bundle between client logic (master) and the interval scheduler (slave).
// abort/aborted exist only when INTERVAL_SCHED_ABORT_EN is defined.
interface interval_scheduler_if import interval_sched_pkg::*; #(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int CNT_W   = DEF_CNT_W
) ();
  // req is a level held by a client until its done pulse; len is sampled when the grant is taken.
  logic [NUM_REQ-1:0]       req;
  logic [NUM_REQ*CNT_W-1:0] len;
  logic [NUM_REQ-1:0]       gnt;
  logic [NUM_REQ-1:0]       done;
  logic                     busy;
  logic [CNT_W-1:0]         count_out;
`ifdef INTERVAL_SCHED_ABORT_EN
  logic                     abort;
  logic                     aborted;

  modport master (output req, len, abort, input gnt, done, busy, count_out, aborted);
  modport slave  (input req, len, abort, output gnt, done, busy, count_out, aborted);
`else
  modport master (output req, len, input gnt, done, busy, count_out);
  modport slave  (input req, len, output gnt, done, busy, count_out);
`endif
endinterface

// File: rtl/interval_scheduler_count_core.sv
// Shared CNT_W-bit up-counter with synchronous clear and enable; clear wins over enable.
module interval_count_core #(
  parameter int CNT_W = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             enable,
  output logic [CNT_W-1:0] count
);
  always_ff @(posedge clock) begin
    if (reset || clear) count <= '0;
    else if (enable)    count <= count + 1'b1;
  end
endmodule

// File: rtl/interval_scheduler.sv
// Round-robin scheduler sequencing one shared counter for NUM_REQ interval requesters.
// Optional abort feature: define INTERVAL_SCHED_ABORT_EN.
module interval_scheduler import interval_sched_pkg::*; #(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int CNT_W   = DEF_CNT_W
) (
  input  logic                 clock,
  input  logic                 reset,
  interval_scheduler_if.slave  bus,
  output state_t               state_dbg
);
  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  state_t             state, state_n;
  logic [IDX_W-1:0]   rr_ptr, idx_q, pick, cand;
  logic               found;
  logic [CNT_W-1:0]   len_q, count;
  logic               cnt_clear, cnt_en, abort_in;
  logic [NUM_REQ-1:0] gnt_q, done_q;
  logic               busy_q;

`ifdef INTERVAL_SCHED_ABORT_EN
  assign abort_in = bus.abort;
`else
  assign abort_in = 1'b0;
`endif

  // Search starts at rr_ptr and wraps, so the last-served requester goes to the back.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    cand  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (int'(rr_ptr) + k >= NUM_REQ) cand = IDX_W'(int'(rr_ptr) + k - NUM_REQ);
      else                             cand = IDX_W'(int'(rr_ptr) + k);
      if (!found && bus.req[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  always_comb begin
    state_n   = state;
    cnt_clear = 1'b0;
    cnt_en    = 1'b0;
    case (state)
      IDLE:  if (found) state_n = CLEAR;
      CLEAR: begin
        if (abort_in) state_n = DONE;
        else begin
          cnt_clear = 1'b1;
          state_n   = RUN;
        end
      end
      RUN: begin
        if (abort_in || count == len_q) state_n = DONE;
        else                            cnt_en  = 1'b1;
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Outputs are registered from state_n so they line up with the state they describe.
  always_ff @(posedge clock) begin
    if (reset) begin
      state  <= IDLE;
      rr_ptr <= '0;
      idx_q  <= '0;
      len_q  <= '0;
      gnt_q  <= '0;
      done_q <= '0;
      busy_q <= 1'b0;
    end else begin
      state  <= state_n;
      busy_q <= (state_n != IDLE);
      done_q <= (state_n == DONE) ? (NUM_REQ'(1) << idx_q) : '0;
      if (state == IDLE && found) begin
        idx_q <= pick;
        len_q <= bus.len[pick*CNT_W +: CNT_W];
        gnt_q <= NUM_REQ'(1) << pick;
      end else if (state_n == IDLE) begin
        gnt_q <= '0;
      end
      if (state == DONE)
        rr_ptr <= (idx_q == IDX_W'(NUM_REQ-1)) ? '0 : idx_q + 1'b1;
    end
  end

`ifdef INTERVAL_SCHED_ABORT_EN
  logic aborted_q;
  always_ff @(posedge clock) begin
    if (reset) aborted_q <= 1'b0;
    else       aborted_q <= abort_in && (state == CLEAR || state == RUN);
  end
  assign bus.aborted = aborted_q;
`endif

  interval_count_core #(.CNT_W(CNT_W)) u_count_core (
    .clock  (clock),
    .reset  (reset),
    .clear  (cnt_clear),
    .enable (cnt_en),
    .count  (count)
  );

  assign bus.gnt       = gnt_q;
  assign bus.done      = done_q;
  assign bus.busy      = busy_q;
  assign bus.count_out = count;
  assign state_dbg     = state;
endmodule
